// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: write-back selects,
// FSM state encoding and the default ack timeout.
package mem_pkg;

    localparam logic [1:0] WD_SEL_ALU  = 2'b00;
    localparam logic [1:0] WD_SEL_DRAM = 2'b01;
    localparam logic [1:0] WD_SEL_WD   = 2'b10;

    localparam int ACK_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port between the MEM stage and data memory.
interface mem_access_unit_if;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_ack_timer.sv
// Ack watchdog: counts cycles spent waiting for memory and flags the last
// permitted cycle so the access can be abandoned.
module mem_ack_timer
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Expiry is reached before the counter could wrap, so no saturation is needed.
    assign expire = (cnt == 8'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit with registered write-back and ack watchdog.
// Optional MEM_ALIGN_CHECK_EN rejects word accesses whose address is not 4-byte aligned.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         wd_sel_i,
    input  logic               rf_we_i,
    input  logic               dram_we_i,
    input  logic [4:0]         wR_i,
    input  logic [31:0]        wD_i,
    input  logic [31:0]        alu_c_i,
    input  logic [31:0]        rD2_i,
    mem_access_unit_if.master  mem,
    output logic               stall_o,
    output logic               wb_we_o,
    output logic [4:0]         wb_wR_o,
    output logic [31:0]        wb_wD_o,
    output logic               err_o,
    output logic               misalign_o
);

    state_t      state;
    logic [31:0] load_buf;
    logic        err_flag;
    logic        mis_flag;
    logic        is_mem;
    logic        misaligned;
    logic        expire;

    function automatic logic [31:0] wb_data(input logic [1:0]  sel,
                                            input logic [31:0] alu,
                                            input logic [31:0] wd,
                                            input logic [31:0] lbuf);
        case (sel)
            WD_SEL_DRAM: return lbuf;
            WD_SEL_WD:   return wd;
            default:     return alu;
        endcase
    endfunction

    assign is_mem = dram_we_i | (wd_sel_i == WD_SEL_DRAM);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = |alu_c_i[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Reset also releases the stall so the pipeline is not held while the unit is cleared.
    assign stall_o = rst_n & (((state == ST_IDLE) & is_mem) | (state == ST_ACCESS));

    mem_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == ST_IDLE),
        .en     ((state == ST_ACCESS) & ~mem.mem_ack_i & ~expire),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= '0;
            mem.mem_wdata_o <= '0;
            load_buf        <= '0;
            err_flag        <= 1'b0;
            mis_flag        <= 1'b0;
            wb_we_o         <= 1'b0;
            wb_wR_o         <= '0;
            wb_wD_o         <= '0;
            err_o           <= 1'b0;
            misalign_o      <= 1'b0;
        end else begin
            err_o      <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (is_mem) begin
                        wb_we_o <= 1'b0;
                        if (misaligned) begin
                            load_buf <= '0;
                            mis_flag <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            mem.mem_req_o   <= 1'b1;
                            mem.mem_we_o    <= dram_we_i;
                            mem.mem_addr_o  <= alu_c_i;
                            mem.mem_wdata_o <= rD2_i;
                            state           <= ST_ACCESS;
                        end
                    end else begin
                        wb_we_o <= rf_we_i;
                        wb_wR_o <= wR_i;
                        wb_wD_o <= wb_data(wd_sel_i, alu_c_i, wD_i, load_buf);
                    end
                end
                ST_ACCESS: begin
                    wb_we_o <= 1'b0;
                    if (mem.mem_ack_i) begin
                        load_buf      <= mem.mem_rdata_i;
                        mem.mem_req_o <= 1'b0;
                        state         <= ST_DONE;
                    end else if (expire) begin
                        load_buf      <= '0;
                        err_flag      <= 1'b1;
                        mem.mem_req_o <= 1'b0;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // EX/MEM is still frozen here, so its fields still describe this access.
                    wb_we_o    <= rf_we_i;
                    wb_wR_o    <= wR_i;
                    wb_wD_o    <= wb_data(wd_sel_i, alu_c_i, wD_i, load_buf);
                    err_o      <= err_flag;
                    misalign_o <= mis_flag;
                    err_flag   <= 1'b0;
                    mis_flag   <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed ops push expected write-backs,
// a negedge monitor pops and compares them as the unit presents them.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wd_sel_i;
    logic        rf_we_i;
    logic        dram_we_i;
    logic [4:0]  wR_i;
    logic [31:0] wD_i;
    logic [31:0] alu_c_i;
    logic [31:0] rD2_i;
    logic        stall_o;
    logic        wb_we_o;
    logic [4:0]  wb_wR_o;
    logic [31:0] wb_wD_o;
    logic        err_o;
    logic        misalign_o;

    always #5 clk = ~clk;

    mem_access_unit_if mif ();

    mem_access_unit #(.ACK_TIMEOUT(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wd_sel_i   (wd_sel_i),
        .rf_we_i    (rf_we_i),
        .dram_we_i  (dram_we_i),
        .wR_i       (wR_i),
        .wD_i       (wD_i),
        .alu_c_i    (alu_c_i),
        .rD2_i      (rD2_i),
        .mem        (mif),
        .stall_o    (stall_o),
        .wb_we_o    (wb_we_o),
        .wb_wR_o    (wb_wR_o),
        .wb_wD_o    (wb_wD_o),
        .err_o      (err_o),
        .misalign_o (misalign_o)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        err;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Monitor: any presented write-back, error or misalign pulse consumes one expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (wb_we_o || err_o || misalign_o)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL wb_unexpected: got we=%0b wR=%0d wD=%h err=%0b mis=%0b, required no output",
                         wb_we_o, wb_wR_o, wb_wD_o, err_o, misalign_o);
            end else begin
                e = exp_q.pop_front();
                check("wb_we",  32'(wb_we_o),    32'(e.we));
                check("wb_wR",  32'(wb_wR_o),    32'(e.wr));
                check("wb_wD",  wb_wD_o,         e.wd);
                check("err",    32'(err_o),      32'(e.err));
                check("mis",    32'(misalign_o), 32'(e.mis));
            end
        end
    end

    task automatic drive(input logic [1:0] sel, input logic rfwe, input logic dwe,
                         input logic [4:0] wr, input logic [31:0] wd,
                         input logic [31:0] alu, input logic [31:0] rd2);
        wd_sel_i  = sel;
        rf_we_i   = rfwe;
        dram_we_i = dwe;
        wR_i      = wr;
        wD_i      = wd;
        alu_c_i   = alu;
        rD2_i     = rd2;
    endtask

    task automatic idle_in();
        drive(2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    // Holds one instruction until the unit stops stalling; ack_cyc counts from presentation (cycle 0).
    task automatic run_op(input logic [1:0] sel, input logic rfwe, input logic dwe,
                          input logic [4:0] wr, input logic [31:0] wd,
                          input logic [31:0] alu, input logic [31:0] rd2,
                          input int ack_cyc, input logic [31:0] rdata,
                          output int stalls, output int reqs, output int bus_bad);
        bit done = 1'b0;
        stalls  = 0;
        reqs    = 0;
        bus_bad = 0;
        drive(sel, rfwe, dwe, wr, wd, alu, rd2);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            mif.mem_ack_i   = (cyc == ack_cyc);
            mif.mem_rdata_i = (cyc == ack_cyc) ? rdata : 32'h0BAD0BAD;
            @(negedge clk);
            if (stall_o) stalls++;
            else done = 1'b1;
            if (mif.mem_req_o) begin
                reqs++;
                if (mif.mem_addr_o !== alu || mif.mem_we_o !== dwe || mif.mem_wdata_o !== rd2)
                    bus_bad++;
            end
            @(posedge clk);
            #1;
        end
        mif.mem_ack_i = 1'b0;
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL op_bound: got stall still high after 40 cycles, required release");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int st, rq, bb;
        idle_in();
        mif.mem_ack_i   = 1'b0;
        mif.mem_rdata_i = 32'h0;
        #12;
        check("rst_req",   32'(mif.mem_req_o), 32'd0);
        check("rst_addr",  mif.mem_addr_o,     32'd0);
        check("rst_stall", 32'(stall_o),       32'd0);
        check("rst_wb_we", 32'(wb_we_o),       32'd0);
        check("rst_wb_wD", wb_wD_o,            32'd0);
        check("rst_err",   32'(err_o),         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU write-back paths, including the reserved select
        exp_q.push_back(exp_t'{1'b1, 5'd5, 32'h1234, 1'b0, 1'b0});
        run_op(WD_SEL_ALU, 1'b1, 1'b0, 5'd5, 32'h0, 32'h1234, 32'h0, -1, 32'h0, st, rq, bb);
        check("alu_stall", 32'(st), 32'd0);
        check("alu_req",   32'(rq), 32'd0);
        exp_q.push_back(exp_t'{1'b1, 5'd6, 32'h1004, 1'b0, 1'b0});
        run_op(WD_SEL_WD, 1'b1, 1'b0, 5'd6, 32'h1004, 32'h777, 32'h0, -1, 32'h0, st, rq, bb);
        check("wd_stall", 32'(st), 32'd0);
        exp_q.push_back(exp_t'{1'b1, 5'd31, 32'h55AA, 1'b0, 1'b0});
        run_op(2'b11, 1'b1, 1'b0, 5'd31, 32'h999, 32'h55AA, 32'h0, -1, 32'h0, st, rq, bb);
        check("rsv_stall", 32'(st), 32'd0);

        // Load, ack in the third ACCESS cycle
        exp_q.push_back(exp_t'{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0});
        run_op(WD_SEL_DRAM, 1'b1, 1'b0, 5'd7, 32'h0, 32'h100, 32'h0, 3, 32'hDEADBEEF, st, rq, bb);
        check("ld_stall", 32'(st), 32'd4);
        check("ld_req",   32'(rq), 32'd3);
        check("ld_bus",   32'(bb), 32'd0);

        // Store, ack in the first ACCESS cycle
        run_op(WD_SEL_ALU, 1'b0, 1'b1, 5'd0, 32'h0, 32'h40, 32'hA5A5A5A5, 1, 32'h0, st, rq, bb);
        check("st_stall", 32'(st), 32'd2);
        check("st_req",   32'(rq), 32'd1);
        check("st_bus",   32'(bb), 32'd0);
        idle_in();
        @(negedge clk);
        check("st_wb_we", 32'(wb_we_o), 32'd0);
        @(posedge clk);
        #1;

        // Timeout with late acks in DONE and in the following IDLE
        exp_q.push_back(exp_t'{1'b1, 5'd9, 32'h0, 1'b1, 1'b0});
        run_op(WD_SEL_DRAM, 1'b1, 1'b0, 5'd9, 32'h0, 32'h200, 32'h0, T + 1, 32'hFFFFFFFF, st, rq, bb);
        check("to_stall", 32'(st), 32'(T + 1));
        check("to_req",   32'(rq), 32'(T));
        exp_q.push_back(exp_t'{1'b1, 5'd10, 32'hBEE, 1'b0, 1'b0});
        run_op(WD_SEL_ALU, 1'b1, 1'b0, 5'd10, 32'h0, 32'hBEE, 32'h0, 0, 32'h12345678, st, rq, bb);
        check("late_ack_stall", 32'(st), 32'd0);

        // Load at an unaligned address
`ifdef MEM_ALIGN_CHECK_EN
        exp_q.push_back(exp_t'{1'b1, 5'd4, 32'h0, 1'b0, 1'b1});
        run_op(WD_SEL_DRAM, 1'b1, 1'b0, 5'd4, 32'h0, 32'h102, 32'h0, -1, 32'h0, st, rq, bb);
        check("mis_stall", 32'(st), 32'd1);
        check("mis_req",   32'(rq), 32'd0);
`else
        exp_q.push_back(exp_t'{1'b1, 5'd4, 32'h11223344, 1'b0, 1'b0});
        run_op(WD_SEL_DRAM, 1'b1, 1'b0, 5'd4, 32'h0, 32'h102, 32'h0, 1, 32'h11223344, st, rq, bb);
        check("ua_stall", 32'(st), 32'd2);
        check("ua_req",   32'(rq), 32'd1);
        check("ua_bus",   32'(bb), 32'd0);
`endif

        // Asynchronous reset during the second ACCESS cycle
        drive(WD_SEL_DRAM, 1'b1, 1'b0, 5'd12, 32'h0, 32'h300, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_req", 32'(mif.mem_req_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_req",   32'(mif.mem_req_o), 32'd0);
        check("rst_mid_stall", 32'(stall_o),       32'd0);
        idle_in();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(exp_t'{1'b1, 5'd3, 32'hCAFE, 1'b0, 1'b0});
        run_op(WD_SEL_ALU, 1'b1, 1'b0, 5'd3, 32'h0, 32'hCAFE, 32'h0, -1, 32'h0, st, rq, bb);
        check("post_rst_stall", 32'(st), 32'd0);

        idle_in();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage consumer of the EX/MEM pipeline register: decodes its control fields, performs the data-memory load or store over a req/ack handshake, and produces the registered write-back triple (we, register index, data) for the MEM/WB boundary. It sits between the EX/MEM register and the data-memory port. It holds the upstream pipeline frozen via `stall_o` while an access is outstanding. An ack-timeout watchdog prevents a dead memory from hanging the core.

## Interface
- `ACK_TIMEOUT`, 16: maximum cycles spent in ACCESS before the access is aborted; legal range 2..255.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wd_sel_i`  in  2  write-back select from EX/MEM: 00 ALU result, 01 DRAM read data, 10 `wD_i`, 11 reserved (treated as 00).
- `rf_we_i`  in  1  register-file write enable from EX/MEM.
- `dram_we_i`  in  1  store request from EX/MEM.
- `wR_i`  in  5  destination register.
- `wD_i`  in  32  precomputed write-back value (pc+4 / immediate).
- `alu_c_i`  in  32  ALU result; byte address for memory ops.
- `rD2_i`  in  32  store data.
- `mem_req_o`  out  1  memory request, held until ack.
- `mem_we_o`  out  1  1 = write, 0 = read.
- `mem_addr_o`  out  32  access address.
- `mem_wdata_o`  out  32  store data.
- `mem_ack_i`  in  1  memory completion; `mem_rdata_i` valid in the same cycle for reads.
- `mem_rdata_i`  in  32  read data.
- `stall_o`  out  1  freezes EX/MEM and earlier stages (combinational).
- `wb_we_o`  out  1  registered write-back enable.
- `wb_wR_o`  out  5  registered write-back index.
- `wb_wD_o`  out  32  registered write-back data.
- `err_o`  out  1  one-cycle pulse: access timed out.
- `misalign_o`  out  1  one-cycle pulse: misaligned access rejected.

## Operation
- Memory op: `is_mem = dram_we_i | (wd_sel_i == 01)`.
- FSM has three states: IDLE, ACCESS, DONE.
  - IDLE, `is_mem`=0: no stall. The wb registers load `rf_we_i`, `wR_i`, and the selected data (00/11: `alu_c_i`, 10: `wD_i`).
  - IDLE, `is_mem`=1: `stall_o`=1. The unit registers `mem_we_o`=`dram_we_i`, `mem_addr_o`=`alu_c_i` and `mem_wdata_o`=`rD2_i`, sets `mem_req_o`=1, clears the timeout counter, and moves to ACCESS. `wb_we_o` is loaded 0 (bubble).
  - ACCESS: `stall_o`=1. `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` stay stable. `wb_we_o` is loaded 0.
    - On `mem_ack_i`: capture `mem_rdata_i` into the internal load buffer, drop `mem_req_o`, go to DONE.
    - If no ack and the counter equals `ACK_TIMEOUT`-1: drop `mem_req_o`, load buffer := 0, set the error flag, go to DONE.
    - Otherwise the counter increments.
  - DONE: `stall_o`=0. The wb registers load `rf_we_i` and `wR_i`, with data = load buffer for sel 01. `err_o` pulses if the error flag is set, then the flag clears. The FSM returns to IDLE.
- Stores reach write-back with `rf_we_i` as supplied (0 from decode). The unit does not force it.
- An ack arriving in IDLE or DONE is ignored.
- The unit does not check write-back to x0; that is handled at the register file.

## Timing
- All outputs reset to 0 and the FSM resets to IDLE. An asynchronous reset mid-ACCESS drops `mem_req_o` immediately and discards the access.
- Non-memory op: write-back visible 1 cycle after presentation, no stall.
- Memory op presented in cycle 0, ack in cycle k (k ≥ 1):
  - `stall_o` is high in cycles 0..k.
  - DONE occurs in cycle k+1.
  - Write-back is visible in cycle k+2.
- Minimum stall is 2 cycles.
- Timeout: with no ack, the FSM is in DONE `ACK_TIMEOUT`+1 cycles after presentation, and `err_o` is high during the cycle after DONE.
- Counter width is 8 bits and it never wraps, because the timeout fires first.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - In IDLE with `is_mem` and `alu_c_i[1:0]` ≠ 00, no request is issued.
  - The FSM goes directly to DONE with load buffer := 0.
  - `misalign_o` pulses in the cycle following DONE, aligned with the write-back.
  - Stall lasts 1 cycle.
- `MEM_ALIGN_CHECK_EN` undefined: the full address is passed unmodified and `misalign_o` is tied 0.

## Structure
- Package `mem_pkg`:
  - `wd_sel` constants: `WD_SEL_ALU`=00, `WD_SEL_DRAM`=01, `WD_SEL_WD`=10.
  - FSM state enum.
  - Default `ACK_TIMEOUT`.
- Sub-module `mem_ack_timer`: clear/enable inputs, `expire` output. It holds the counter and the compare against `ACK_TIMEOUT`-1.

## Test plan
- ALU op with `wd_sel`=00, `alu_c_i`=0x1234, `wR_i`=5, `rf_we_i`=1 → next cycle `wb_we_o`=1, `wb_wR_o`=5, `wb_wD_o`=0x1234; `stall_o` never high.
- Load from addr 0x100, ack with rdata 0xDEADBEEF 3 cycles after req → `stall_o` high 4 cycles; `wb_wD_o`=0xDEADBEEF; `mem_addr_o`=0x100 stable throughout.
- Store of `rD2_i`=0xA5A5A5A5 to 0x40, `rf_we_i`=0, same-cycle ack → `mem_we_o`=1, `mem_wdata_o`=0xA5A5A5A5; stall 2 cycles; `wb_we_o`=0.
- Load with no ack, `ACK_TIMEOUT`=4 → `mem_req_o` high exactly 4 cycles; `err_o` one-cycle pulse; `wb_wD_o`=0; a late ack is ignored.
- `rst_n` asserted low in the 2nd ACCESS cycle → `mem_req_o` and `stall_o` drop immediately; after release a new ALU op writes back normally.
- With `MEM_ALIGN_CHECK_EN`, load at 0x102 → no `mem_req_o`; `misalign_o` pulse; `wb_wD_o`=0; stall 1 cycle.
